seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 The module SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits, legal range 2..16.
REQ-002 The module SHALL have parameter PAT_RST, default 4'b0101 sized PAT_LEN, giving the pattern active after reset.
REQ-003 The module SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The module SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-005 clk  in  1  Single clock; all state updates on its rising edge.
REQ-006 reset  in  1  Asynchronous, active-low reset.
REQ-007 din  in  1  Serial data bit.
REQ-008 din_valid  in  1  din is sampled only when this is high.
REQ-009 pat_load  in  1  One-cycle strobe loading pat_in as the new pattern.
REQ-010 pat_in  in  PAT_LEN  New pattern; MSB is the first-received bit.
REQ-011 cnt_clr  in  1  Synchronous clear of match_count.
REQ-012 z  out  1  Registered one-cycle match pulse.
REQ-013 armed  out  1  High once PAT_LEN valid bits are held since the last clear.
REQ-014 match_count  out  CNT_W  Saturating count of detected matches.

Function
REQ-015 The FSM SHALL have states FILL (fewer than PAT_LEN bits held) and RUN (window full).
- FILL -> RUN when the PAT_LEN-th valid bit is accepted.
- RUN -> FILL on a match with OVERLAP=0, or on pat_load.
REQ-016 Each din_valid beat SHALL shift din into the LSB of a PAT_LEN-bit history register and increment the fill count, which saturates at PAT_LEN.
REQ-017 A match SHALL occur when the beat completing a full window makes the history equal the pattern; z SHALL be high for exactly the next cycle (latency 1).
REQ-018 With OVERLAP=1 the history SHALL be retained after a match, so 0101010 yields two pulses.
REQ-019 With OVERLAP=0 the fill count SHALL clear on a match, so 0101010 yields one pulse.
REQ-020 With din_valid low, history, state and fill count SHALL hold, and z SHALL be low in the following cycle.
REQ-021 On pat_load the pattern register SHALL take pat_in and the history and fill count SHALL clear; a din_valid beat in the same cycle SHALL be discarded.
REQ-022 armed SHALL equal (state == RUN).
REQ-023 match_count SHALL increment on each match and hold at all-ones when saturated.
REQ-024 When cnt_clr and a match coincide, cnt_clr SHALL win and the count SHALL become 0.

Reset
REQ-025 While reset is low, the outputs SHALL be z=0, armed=0, match_count=0, state=FILL, history=0, fill count=0 and pattern=PAT_RST.
REQ-026 Reset asserted mid-window SHALL discard partial history; detection SHALL restart from an empty window after release.

Configuration
REQ-027 With macro SEQ_DET_COUNT_EN defined, the match counter SHALL be implemented as specified.
REQ-028 Without SEQ_DET_COUNT_EN, match_count SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL exist; the ports SHALL remain present.

Structure
REQ-029 Package seq_det_pkg SHALL hold the FSM state typedef (FILL, RUN) and the default constants PAT_LEN_DEF=4 and CNT_W_DEF=8.
REQ-030 The design SHALL be a single module with no sub-module; the history shifter is inline.

Verification
REQ-031 With defaults, OVERLAP=1, feed 0,1,0,1,0,1 valid back-to-back -> z pulses the cycle after beats 4 and 6; match_count=2.
REQ-032 With OVERLAP=0, feed the same stream -> one z pulse, after beat 4; match_count=1; armed drops after the match.
REQ-033 Feed 0,1 then din_valid=0 for 3 cycles then 0,1 -> z pulses once, after the final beat; no pulse during the gap.
REQ-034 pat_load with pat_in=4'b1100 coinciding with a beat, then feed 1,1,0,0 -> one match; the coincident beat is ignored; no match on an old-pattern stream.
REQ-035 With CNT_W=2, produce 5 matches -> match_count holds at 3; cnt_clr coincident with a 6th match -> count is 0.
REQ-036 Assert reset after 3 beats of 0101, release, then feed 1 -> no z pulse; armed=0; pattern equals PAT_RST.

Source files
------------

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parameterised serial sequence detector.
//   state_t      : detector FSM state (FILL = window not yet full,
//                  RUN = PAT_LEN valid bits held)
//   PAT_LEN_DEF  : default pattern length in bits
//   CNT_W_DEF    : default match counter width
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PAT_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_det_param.sv
// ---------------------------------------------------------------------------
// seq_det_param
// Serial pattern detector with a run-time loadable pattern, selectable
// overlapping / non-overlapping detection and an optional saturating match
// counter.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PAT_RST  pattern active after reset
//   OVERLAP  1 = overlapping detection, 0 = window restarts after a match
//   CNT_W    match counter width
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   din          serial data bit
//   din_valid    din is accepted only while high
//   pat_load     one-cycle strobe: pat_in becomes the pattern, window clears
//   pat_in       new pattern, MSB is the first-received bit
//   cnt_clr      synchronous clear of match_count (wins over a match)
//   z            registered one-cycle match pulse (latency 1 beat)
//   armed        high while the FSM is in RUN; this is the FSM state view
//   match_count  saturating number of matches
//
// Build option
//   SEQ_DET_COUNT_EN  when defined the match counter is built; otherwise
//                     match_count is tied to zero and cnt_clr is ignored.
//
// Handshake: a beat is one rising edge with din_valid high; there is no
// back-pressure, every valid beat is consumed unless pat_load is also high,
// in which case the beat is dropped.
// ---------------------------------------------------------------------------
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(4'b0101),
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               z,
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    state_t             state;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_nxt;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_nxt;
    logic               hit;

    // Next window contents for a beat; a match needs the window to be full
    // after the beat, so the first PAT_LEN-1 beats can never match.
    always_comb begin
        hist_nxt = {hist[PAT_LEN-2:0], din};
        fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit      = din_valid && !pat_load &&
                   (fill_nxt == FILL_FULL) && (hist_nxt == pattern);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            hist    <= '0;
            fill    <= '0;
            pattern <= PAT_RST;
            z       <= 1'b0;
        end else begin
            z <= hit;
            if (pat_load) begin
                pattern <= pat_in;
                hist    <= '0;
                fill    <= '0;
                state   <= FILL;
            end else if (din_valid) begin
                hist <= hist_nxt;
                if (hit && OVERLAP == 0) begin
                    // Non-overlapping: the next match needs PAT_LEN fresh bits.
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill  <= fill_nxt;
                    state <= (fill_nxt == FILL_FULL) ? RUN : FILL;
                end
            end
        end
    end

    assign armed = (state == RUN);

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (hit && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// ---------------------------------------------------------------------------
// tb_seq_det_param
// Three detector instances share one stimulus stream:
//   u_ov  : defaults (OVERLAP=1, CNT_W=8)
//   u_nov : OVERLAP=0
//   u_c2  : OVERLAP=1, CNT_W=2 (counter saturation)
// A reference model tracks the last PAT_LEN accepted bits as an integer
// window plus a count of bits held, and predicts z / armed / match_count
// after every clock.
// ---------------------------------------------------------------------------
module tb_seq_det_param;

  localparam int L = 4;
  localparam int PAT_RST_V = 5;  // 4'b0101

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;

  logic       z0, z1, z2;
  logic       armed0, armed1, armed2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  seq_det_param #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z0), .armed(armed0), .match_count(cnt0)
  );

  seq_det_param #(.OVERLAP(0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z1), .armed(armed1), .match_count(cnt1)
  );

  seq_det_param #(.OVERLAP(1), .CNT_W(2)) u_c2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z2), .armed(armed2), .match_count(cnt2)
  );

  // ---------------- reference model ----------------
  int ov_cfg[3]   = '{1, 0, 1};
  int cnt_max[3]  = '{255, 255, 3};
  int m_win[3];
  int m_held[3];
  int m_cnt[3];
  int m_z[3];
  int m_pat;
  int pulses[3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_win[i]  = 0;
      m_held[i] = 0;
      m_cnt[i]  = 0;
      m_z[i]    = 0;
    end
    m_pat = PAT_RST_V;
  endfunction

  function automatic void model_step(input int d, input int v, input int l,
                                     input int p, input int c);
    for (int i = 0; i < 3; i++) begin
      m_z[i] = 0;
      if (l != 0) begin
        m_win[i]  = 0;
        m_held[i] = 0;
      end else if (v != 0) begin
        m_win[i]  = (m_win[i] * 2 + d) % (1 << L);
        m_held[i] = (m_held[i] < L) ? m_held[i] + 1 : L;
        if (m_held[i] == L && m_win[i] == m_pat) begin
          m_z[i] = 1;
          if (ov_cfg[i] == 0) m_held[i] = 0;
        end
      end
`ifdef SEQ_DET_COUNT_EN
      if (c != 0) m_cnt[i] = 0;
      else if (m_z[i] == 1 && m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
`else
      m_cnt[i] = 0;
`endif
    end
    if (l != 0) m_pat = p;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef SEQ_DET_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/z_ov"},      {31'b0, z0},     m_z[0]);
    check({tag, "/z_nov"},     {31'b0, z1},     m_z[1]);
    check({tag, "/z_c2"},      {31'b0, z2},     m_z[2]);
    check({tag, "/armed_ov"},  {31'b0, armed0}, (m_held[0] == L) ? 1 : 0);
    check({tag, "/armed_nov"}, {31'b0, armed1}, (m_held[1] == L) ? 1 : 0);
    check({tag, "/armed_c2"},  {31'b0, armed2}, (m_held[2] == L) ? 1 : 0);
    check({tag, "/cnt_ov"},    {24'b0, cnt0},   m_cnt[0]);
    check({tag, "/cnt_nov"},   {24'b0, cnt1},   m_cnt[1]);
    check({tag, "/cnt_c2"},    {30'b0, cnt2},   m_cnt[2]);
    if (z0 === 1'b1) pulses[0]++;
    if (z1 === 1'b1) pulses[1]++;
    if (z2 === 1'b1) pulses[2]++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int d, input int v, input int l, input int p,
                      input int c, input string tag);
    @(negedge clk);
    din       = d[0];
    din_valid = v[0];
    pat_load  = l[0];
    pat_in    = p[3:0];
    cnt_clr   = c[0];
    model_step(d, v, l, p, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic feed(input int bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step((bits >> i) & 1, 1, 0, 0, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    din = 1'b0; din_valid = 1'b0; pat_load = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic void clear_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset = 1'b0;
    din = 1'b0; din_valid = 1'b0; pat_load = 1'b0; pat_in = 4'h0; cnt_clr = 1'b0;
    model_reset();
    clear_pulses();

    do_reset("reset");

    // 0,1,0,1,0,1 back-to-back
    clear_pulses();
    feed(6'b010101, 6, "ov_stream");
    check("ov_pulses",  pulses[0], 2);
    check("nov_pulses", pulses[1], 1);
    check("ov_count",   {24'b0, cnt0}, exp_cnt(2));
    check("nov_count",  {24'b0, cnt1}, exp_cnt(1));
    check("nov_armed_after", {31'b0, armed1}, 0);

    // 0,1, three idle cycles, 0,1
    do_reset("reset_gap");
    clear_pulses();
    feed(2'b01, 2, "gap_a");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "gap_idle");
    check("gap_no_pulse", pulses[0], 0);
    feed(2'b01, 2, "gap_b");
    check("gap_pulse", {31'b0, z0}, 1);

    // load 1100 with a coincident beat, old pattern stream, then 1,1,0,0
    clear_pulses();
    step(1, 1, 1, 4'b1100, 0, "load");
    feed(4'b0101, 4, "old_pat");
    check("old_pat_none", pulses[0] + pulses[1], 0);
    feed(4'b1100, 4, "new_pat");
    check("new_pat_ov",  pulses[0], 1);
    check("new_pat_nov", pulses[1], 1);

    // saturation: five matches, then a sixth coincident with cnt_clr
    do_reset("reset_sat");
    feed(4'b0101, 4, "sat_first");
    for (int i = 0; i < 4; i++) feed(2'b01, 2, "sat_more");
    check("sat_c2", {30'b0, cnt2}, exp_cnt(3));
    check("sat_ov", {24'b0, cnt0}, exp_cnt(5));
    step(0, 1, 0, 0, 0, "sat_six_a");
    step(1, 1, 0, 0, 1, "sat_six_clr");
    check("clr_wins_z", {31'b0, z2}, 1);
    check("clr_wins_c2", {30'b0, cnt2}, 0);

    // reset mid-window with a loaded pattern; pattern must return to 0101
    step(0, 0, 1, 4'b1100, 0, "pre_rst_load");
    clear_pulses();
    feed(3'b010, 3, "mid_win");
    do_reset("reset_mid");
    step(1, 1, 0, 0, 0, "post_rst_bit");
    check("post_rst_z", {31'b0, z0}, 0);
    check("post_rst_armed", {31'b0, armed0}, 0);
    do_reset("reset_pat");
    feed(4'b0101, 4, "pat_rst_check");
    check("pat_rst_match", {31'b0, z0}, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(int'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 31) == 0) ? 1 : 0,
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
